// File: rtl/n101_spi_xfer_ctrl_if.sv
// Signal bundle between the SPI front-end, the byte sequencer and the SPI pin port.
// slave is the sequencer's view; master is the front-end/pin-port view.
interface n101_spi_xfer_ctrl_if #(
    parameter int DIV_W = 12,
    parameter int CS_W  = 4
);
    logic [DIV_W-1:0] io_cfg_div;
    logic             io_cfg_cpol;
    logic             io_cfg_cpha;
    logic [1:0]       io_cfg_proto;
    logic [1:0]       io_cfg_csid;
    logic             io_cfg_cshold;
    logic             io_op_valid;
    logic             io_op_ready;
    logic [7:0]       io_op_data;
    logic             io_op_dir;
    logic             io_op_last;
    logic             io_rx_valid;
    logic [7:0]       io_rx_data;
    logic             io_busy;
    logic             io_spi_sck;
    logic [3:0]       io_spi_dq_o;
    logic [3:0]       io_spi_dq_oe;
    logic [3:0]       io_spi_dq_i;
    logic [CS_W-1:0]  io_spi_cs;

    modport slave (
        input  io_cfg_div, io_cfg_cpol, io_cfg_cpha, io_cfg_proto, io_cfg_csid, io_cfg_cshold,
        input  io_op_valid, io_op_data, io_op_dir, io_op_last, io_spi_dq_i,
        output io_op_ready, io_rx_valid, io_rx_data, io_busy,
        output io_spi_sck, io_spi_dq_o, io_spi_dq_oe, io_spi_cs
    );

    modport master (
        output io_cfg_div, io_cfg_cpol, io_cfg_cpha, io_cfg_proto, io_cfg_csid, io_cfg_cshold,
        output io_op_valid, io_op_data, io_op_dir, io_op_last, io_spi_dq_i,
        input  io_op_ready, io_rx_valid, io_rx_data, io_busy,
        input  io_spi_sck, io_spi_dq_o, io_spi_dq_oe, io_spi_cs
    );
endinterface

// File: rtl/n101_spi_xfer_ctrl.sv
// Byte-level SPI master sequencer: one byte per handshake over 1/2/4 lanes,
// with CPOL/CPHA, programmable SCK divider, CS setup/release and frame hold.
module n101_spi_xfer_ctrl #(
    parameter int DIV_W = 12,
    parameter int CS_W  = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    n101_spi_xfer_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_XFER, S_REL} state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             cpol_q, cpol_d;
    logic             cpha_q, cpha_d;
    logic [1:0]       proto_q, proto_d;
    logic [1:0]       csid_q, csid_d;
    logic             cshold_q, cshold_d;
    logic [7:0]       tx_q, tx_d;
    logic [7:0]       rx_q, rx_d;
    logic             dir_q, dir_d;
    logic             last_q, last_d;
    logic [3:0]       edge_q, edge_d;
    logic             sck_q, sck_d;
    logic             csact_q, csact_d;
    logic [3:0]       dqo_q, dqo_d;
    logic [3:0]       dqoe_q, dqoe_d;
    logic             rxv_q, rxv_d;
    logic [7:0]       rxd_q, rxd_d;

    logic             tick;
    logic [7:0]       data_src;
    logic             dir_src;
    logic [3:0]       drv_bits;
    logic [7:0]       tx_shift;
    logic [7:0]       rx_shift;
    logic [3:0]       lane_oe;
    logic [3:0]       last_edge;

    assign tick = (cnt_q == div_q);

    // In IDLE the byte being accepted is still on the op bus, so XFER-entry
    // drive (straight from IDLE with CS held) must take it from there.
    assign data_src = (state_q == S_IDLE) ? bus.io_op_data : tx_q;
    assign dir_src  = (state_q == S_IDLE) ? bus.io_op_dir  : dir_q;

    always_comb begin
        drv_bits  = 4'b0000;
        tx_shift  = data_src;
        rx_shift  = rx_q;
        lane_oe   = 4'b0000;
        last_edge = 4'd15;
        case (proto_q)
            2'd1: begin
                drv_bits  = {2'b00, data_src[7:6]};
                tx_shift  = {data_src[5:0], 2'b00};
                rx_shift  = {rx_q[5:0], bus.io_spi_dq_i[1:0]};
                lane_oe   = dir_src ? 4'b0000 : 4'b0011;
                last_edge = 4'd7;
            end
            2'd2: begin
                drv_bits  = data_src[7:4];
                tx_shift  = {data_src[3:0], 4'b0000};
                rx_shift  = {rx_q[3:0], bus.io_spi_dq_i};
                lane_oe   = dir_src ? 4'b0000 : 4'b1111;
                last_edge = 4'd3;
            end
            default: begin
                drv_bits  = {3'b000, data_src[7]};
                tx_shift  = {data_src[6:0], 1'b0};
                rx_shift  = {rx_q[6:0], bus.io_spi_dq_i[1]};
                lane_oe   = 4'b0001;
                last_edge = 4'd15;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        cpol_d   = cpol_q;
        cpha_d   = cpha_q;
        proto_d  = proto_q;
        csid_d   = csid_q;
        cshold_d = cshold_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        dir_d    = dir_q;
        last_d   = last_q;
        edge_d   = edge_q;
        sck_d    = sck_q;
        csact_d  = csact_q;
        dqo_d    = dqo_q;
        dqoe_d   = dqoe_q;
        rxv_d    = 1'b0;
        rxd_d    = rxd_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                sck_d = csact_q ? cpol_q : bus.io_cfg_cpol;
                if (bus.io_op_valid) begin
                    tx_d   = bus.io_op_data;
                    dir_d  = bus.io_op_dir;
                    last_d = bus.io_op_last;
                    edge_d = 4'd0;
                    if (!csact_q) begin
                        div_d    = bus.io_cfg_div;
                        cpol_d   = bus.io_cfg_cpol;
                        cpha_d   = bus.io_cfg_cpha;
                        proto_d  = bus.io_cfg_proto;
                        csid_d   = bus.io_cfg_csid;
                        cshold_d = bus.io_cfg_cshold;
                        sck_d    = bus.io_cfg_cpol;
                        csact_d  = 1'b1;
                        state_d  = S_SETUP;
                    end else begin
                        state_d = S_XFER;
                        dqoe_d  = lane_oe;
                        if (!cpha_q) begin
                            dqo_d = drv_bits;
                            tx_d  = tx_shift;
                        end
                    end
                end
            end
            S_SETUP: begin
                cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
                if (tick) begin
                    state_d = S_XFER;
                    dqoe_d  = lane_oe;
                    if (!cpha_q) begin
                        dqo_d = drv_bits;
                        tx_d  = tx_shift;
                    end
                end
            end
            S_XFER: begin
                cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
                if (tick) begin
                    sck_d  = ~sck_q;
                    edge_d = edge_q + 4'd1;
                    // Even edges lead, odd edges trail; CPHA picks which one samples.
                    if (!edge_q[0]) begin
                        if (!cpha_q) begin
                            rx_d = rx_shift;
                        end else begin
                            dqo_d = drv_bits;
                            tx_d  = tx_shift;
                        end
                    end else begin
                        if (cpha_q) begin
                            rx_d = rx_shift;
                        end else if (edge_q != last_edge) begin
                            dqo_d = drv_bits;
                            tx_d  = tx_shift;
                        end
                    end
                    if (edge_q == last_edge) begin
                        rxv_d   = 1'b1;
                        rxd_d   = cpha_q ? rx_shift : rx_q;
                        sck_d   = cpol_q;
                        edge_d  = 4'd0;
                        state_d = (last_q && !cshold_q) ? S_REL : S_IDLE;
                    end
                end
            end
            S_REL: begin
                cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
                if (tick) begin
                    csact_d = 1'b0;
                    dqoe_d  = 4'b0000;
                    dqo_d   = 4'b0000;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            div_q    <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            proto_q  <= 2'd0;
            csid_q   <= 2'd0;
            cshold_q <= 1'b0;
            tx_q     <= 8'h00;
            rx_q     <= 8'h00;
            dir_q    <= 1'b0;
            last_q   <= 1'b0;
            edge_q   <= 4'd0;
            sck_q    <= 1'b0;
            csact_q  <= 1'b0;
            dqo_q    <= 4'b0000;
            dqoe_q   <= 4'b0000;
            rxv_q    <= 1'b0;
            rxd_q    <= 8'h00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            cpol_q   <= cpol_d;
            cpha_q   <= cpha_d;
            proto_q  <= proto_d;
            csid_q   <= csid_d;
            cshold_q <= cshold_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            dir_q    <= dir_d;
            last_q   <= last_d;
            edge_q   <= edge_d;
            sck_q    <= sck_d;
            csact_q  <= csact_d;
            dqo_q    <= dqo_d;
            dqoe_q   <= dqoe_d;
            rxv_q    <= rxv_d;
            rxd_q    <= rxd_d;
        end
    end

    assign bus.io_op_ready  = (state_q == S_IDLE);
    assign bus.io_busy      = (state_q != S_IDLE) || csact_q;
    assign bus.io_rx_valid  = rxv_q;
    assign bus.io_rx_data   = rxd_q;
    assign bus.io_spi_sck   = sck_q;
    assign bus.io_spi_dq_o  = dqo_q;
    assign bus.io_spi_dq_oe = dqoe_q;

    // An out-of-range csid matches no index, so no chip select asserts.
    for (genvar g = 0; g < CS_W; g++) begin : g_cs
        assign bus.io_spi_cs[g] = !(csact_q && (int'(csid_q) == g));
    end
endmodule

// File: tb/tb_n101_spi_xfer_ctrl.sv
// Directed bench for n101_spi_xfer_ctrl: rx bytes go through a scoreboard queue,
// SCK edges and lane/CS state are logged by a monitor for per-test checks.
module tb_n101_spi_xfer_ctrl;
    localparam int DIV_W = 12;
    localparam int CS_W  = 4;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    n101_spi_xfer_ctrl_if #(.DIV_W(DIV_W), .CS_W(CS_W)) bus();
    n101_spi_xfer_ctrl #(.DIV_W(DIV_W), .CS_W(CS_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic       loop;
    logic [3:0] dqi_drv;
    assign bus.io_spi_dq_i = loop ? {2'b00, bus.io_spi_dq_o[0], 1'b0} : dqi_drv;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [7:0] exp_q[$];
    int         rx_cnt = 0;
    int         rx_cyc = 0;
    int         lead_cyc[$];
    logic [3:0] lead_dq[$];
    logic [3:0] lead_cs[$];
    logic [3:0] trail_dq[$];
    logic [3:0] trail_oe[$];
    logic [3:0] trail_cs[$];
    logic [3:0] oe_or = 4'h0;
    int         cs_rise = 0;
    int         busy_low = 0;
    logic       mon_cpol = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic bound_fail(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired", nm);
    endtask

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Monitor / scoreboard consumer
    initial begin : monitor
        logic       prev_sck;
        logic       prev_csf;
        logic [7:0] e;
        prev_sck = 1'b0;
        prev_csf = 1'b1;
        forever begin
            @(negedge clock);
            if (reset) begin
                prev_sck = bus.io_spi_sck;
                prev_csf = 1'b1;
            end else begin
                if (bus.io_rx_valid) begin
                    rx_cnt++;
                    rx_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL rx_unexpected: got 0x%02h, expected no rx_valid", bus.io_rx_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rx_data", {24'h0, bus.io_rx_data}, {24'h0, e});
                    end
                end
                if (bus.io_spi_sck !== prev_sck) begin
                    if (bus.io_spi_sck != mon_cpol) begin
                        lead_cyc.push_back(cyc);
                        lead_dq.push_back(bus.io_spi_dq_o);
                        lead_cs.push_back(bus.io_spi_cs);
                    end else begin
                        trail_dq.push_back(bus.io_spi_dq_o);
                        trail_oe.push_back(bus.io_spi_dq_oe);
                        trail_cs.push_back(bus.io_spi_cs);
                    end
                end
                prev_sck = bus.io_spi_sck;
                oe_or    = oe_or | bus.io_spi_dq_oe;
                if (!bus.io_busy) busy_low++;
                if ((bus.io_spi_cs == 4'hF) && !prev_csf) cs_rise++;
                prev_csf = (bus.io_spi_cs == 4'hF);
            end
        end
    end

    task automatic set_cfg(input int div, input logic cpol, input logic cpha,
                           input logic [1:0] proto, input logic [1:0] csid, input logic cshold);
        bus.io_cfg_div    = DIV_W'(div);
        bus.io_cfg_cpol   = cpol;
        bus.io_cfg_cpha   = cpha;
        bus.io_cfg_proto  = proto;
        bus.io_cfg_csid   = csid;
        bus.io_cfg_cshold = cshold;
        mon_cpol          = cpol;
    endtask

    task automatic clr_log();
        lead_cyc.delete();
        lead_dq.delete();
        lead_cs.delete();
        trail_dq.delete();
        trail_oe.delete();
        trail_cs.delete();
        oe_or = 4'h0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Called at a negedge; returns at a negedge with acc = accept cycle.
    task automatic send_op(input logic [7:0] d, input logic dir, input logic last, output int acc);
        int n;
        n = 0;
        bus.io_op_data  = d;
        bus.io_op_dir   = dir;
        bus.io_op_last  = last;
        bus.io_op_valid = 1'b1;
        while (!bus.io_op_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (n >= 200) bound_fail("op_ready_timeout");
        @(posedge clock);
        #1;
        acc = cyc;
        bus.io_op_valid = 1'b0;
        @(negedge clock);
    endtask

    task automatic wait_rx(input int target);
        int n;
        n = 0;
        while (rx_cnt < target && n < 400) begin
            @(negedge clock);
            n++;
        end
        if (rx_cnt < target) bound_fail("rx_valid_timeout");
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int         acc, acc2, base, n, nlead;
        logic [7:0] b;
        logic [1:0] pairs [4];

        reset = 1'b1;
        loop = 1'b0;
        dqi_drv = 4'h0;
        bus.io_op_valid = 1'b0;
        bus.io_op_data  = 8'h00;
        bus.io_op_dir   = 1'b0;
        bus.io_op_last  = 1'b0;
        set_cfg(0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
        wait_cyc(3);

        // reset state
        chk("rst_sck",      {31'h0, bus.io_spi_sck},      32'h0);
        chk("rst_dq_o",     {28'h0, bus.io_spi_dq_o},     32'h0);
        chk("rst_dq_oe",    {28'h0, bus.io_spi_dq_oe},    32'h0);
        chk("rst_cs",       {28'h0, bus.io_spi_cs},       32'hF);
        chk("rst_op_ready", {31'h0, bus.io_op_ready},     32'h1);
        chk("rst_rx_valid", {31'h0, bus.io_rx_valid},     32'h0);
        chk("rst_rx_data",  {24'h0, bus.io_rx_data},      32'h0);
        chk("rst_busy",     {31'h0, bus.io_busy},         32'h0);
        reset = 1'b0;
        wait_cyc(2);

        // 1: single, mode 0, div 0, loopback 0xA5
        loop = 1'b1;
        clr_log();
        exp_q.push_back(8'hA5);
        send_op(8'hA5, 1'b0, 1'b1, acc);
        wait_rx(1);
        wait_cyc(3);
        chk("t1_lead_count", lead_cyc.size(), 8);
        if (lead_cyc.size() >= 2) begin
            chk("t1_first_edge_lat", lead_cyc[0] - acc, 2);
            chk("t1_sck_period",     lead_cyc[1] - lead_cyc[0], 2);
            chk("t1_cs_during",      {28'h0, lead_cs[0]}, 32'hE);
        end
        b = 8'hA5;
        for (int i = 0; i < 8 && i < lead_dq.size(); i++)
            chk("t1_dq0_bit", {31'h0, lead_dq[i][0]}, {31'h0, b[7-i]});
        chk("t1_rx_latency", rx_cyc - acc, 17);
        chk("t1_cs_after",   {28'h0, bus.io_spi_cs}, 32'hF);
        chk("t1_oe_after",   {28'h0, bus.io_spi_dq_oe}, 32'h0);

        // 2: quad receive, div 1
        loop = 1'b0;
        dqi_drv = 4'h3;
        set_cfg(1, 1'b0, 1'b0, 2'd2, 2'd0, 1'b0);
        clr_log();
        exp_q.push_back(8'h3C);
        send_op(8'hFF, 1'b1, 1'b1, acc);
        n = 0;
        while (lead_cyc.size() < 1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (lead_cyc.size() < 1) bound_fail("t2_first_edge_timeout");
        dqi_drv = 4'hC;
        wait_rx(2);
        wait_cyc(4);
        chk("t2_lead_count", lead_cyc.size(), 2);
        if (lead_cyc.size() >= 2) begin
            chk("t2_first_edge_lat", lead_cyc[0] - acc, 4);
            chk("t2_sck_period",     lead_cyc[1] - lead_cyc[0], 4);
        end
        chk("t2_oe_never", {28'h0, oe_or}, 32'h0);
        chk("t2_cs_after", {28'h0, bus.io_spi_cs}, 32'hF);

        // 3: dual tx 0xB4, cpol 1, cpha 1, csid 2; dq_i = {dq1=1,dq0=0}
        dqi_drv = 4'h2;
        set_cfg(0, 1'b1, 1'b1, 2'd1, 2'd2, 1'b0);
        wait_cyc(3);
        chk("t3_sck_idle_hi", {31'h0, bus.io_spi_sck}, 32'h1);
        clr_log();
        exp_q.push_back(8'hAA);
        send_op(8'hB4, 1'b0, 1'b1, acc);
        wait_rx(3);
        wait_cyc(3);
        pairs[0] = 2'd2; pairs[1] = 2'd3; pairs[2] = 2'd1; pairs[3] = 2'd0;
        chk("t3_lead_count",  lead_cyc.size(), 4);
        chk("t3_trail_count", trail_dq.size(), 4);
        for (int i = 0; i < 4 && i < trail_dq.size(); i++) begin
            chk("t3_dq_pair", {28'h0, trail_dq[i]}, {28'h0, 2'b00, pairs[i]});
            chk("t3_oe",      {28'h0, trail_oe[i]}, 32'h3);
            chk("t3_cs",      {28'h0, trail_cs[i]}, 32'hB);
        end
        chk("t3_sck_after", {31'h0, bus.io_spi_sck}, 32'h1);
        chk("t3_cs_after",  {28'h0, bus.io_spi_cs}, 32'hF);

        // 4: back-to-back bytes, last=0 then last=1
        loop = 1'b1;
        set_cfg(0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
        wait_cyc(3);
        clr_log();
        cs_rise = 0;
        base = rx_cnt;
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hC3);
        send_op(8'h3C, 1'b0, 1'b0, acc);
        wait_rx(base + 1);
        nlead = lead_cyc.size();
        send_op(8'hC3, 1'b0, 1'b1, acc2);
        wait_rx(base + 2);
        wait_cyc(3);
        chk("t4_lead_count", lead_cyc.size(), 16);
        if (lead_cyc.size() > nlead)
            chk("t4_byte2_no_setup", lead_cyc[nlead] - acc2, 1);
        chk("t4_rx_pulses", rx_cnt - base, 2);
        chk("t4_single_release", cs_rise, 1);
        chk("t4_cs_after", {28'h0, bus.io_spi_cs}, 32'hF);

        // 5: cshold keeps the frame open across a last byte
        set_cfg(0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1);
        wait_cyc(2);
        clr_log();
        base = rx_cnt;
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'h81);
        send_op(8'h5A, 1'b0, 1'b1, acc);
        busy_low = 0;
        wait_rx(base + 1);
        wait_cyc(4);
        chk("t5_cs_held", {28'h0, bus.io_spi_cs}, 32'hE);
        nlead = lead_cyc.size();
        send_op(8'h81, 1'b0, 1'b1, acc2);
        wait_rx(base + 2);
        wait_cyc(3);
        if (lead_cyc.size() > nlead)
            chk("t5_no_setup", lead_cyc[nlead] - acc2, 1);
        chk("t5_busy_low_cycles", busy_low, 0);
        chk("t5_cs_still_held", {28'h0, bus.io_spi_cs}, 32'hE);

        // 6: reset after 3 SCK edges of a single-mode byte
        clr_log();
        base = rx_cnt;
        send_op(8'h96, 1'b0, 1'b1, acc);
        n = 0;
        while ((lead_cyc.size() + trail_dq.size()) < 3 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if ((lead_cyc.size() + trail_dq.size()) < 3) bound_fail("t6_edge_timeout");
        #2;
        reset = 1'b1;
        #1;
        chk("t6_cs",       {28'h0, bus.io_spi_cs},    32'hF);
        chk("t6_sck",      {31'h0, bus.io_spi_sck},   32'h0);
        chk("t6_oe",       {28'h0, bus.io_spi_dq_oe}, 32'h0);
        chk("t6_op_ready", {31'h0, bus.io_op_ready},  32'h1);
        chk("t6_busy",     {31'h0, bus.io_busy},      32'h0);
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(30);
        chk("t6_no_rx_valid", rx_cnt - base, 0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
